norm2_sequencer: RTL and testbench
==================================

Name: norm2_sequencer

Overview:
Controller that sequences the generated norm2 kernel `main` and its private array `arr_a`. `arr_a` has DEPTH×DW signed entries, 1-cycle read latency, and a single port shared through `controlArr`.
- Streams host data into the array through a load handshake, kicks the kernel, and waits for completion.
- Returns the 64-bit sum of squares, a run-cycle count and an error flag on a result handshake.
- Arbitrates the single array port between host load, host readback and kernel execution.
- Sits between the host fabric and one `main` instance at the accelerator top.

Parameters:
DEPTH, 1000, array entries; kernel loop bound.
AW, 10, array address width.
DW, 27, array data width (signed).
RW, 64, accumulator/result width (signed).
TIMEOUT, 20000, maximum RUN cycles before abort.
CW, 16, run-cycle counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_valid / ld_ready  in/out  1/1  load-stream handshake
ld_data  in  DW  signed word, written at the load pointer
ld_last  in  1  final word of the load
st_valid / st_ready  in/out  1/1  start-command handshake
st_i  in  AW  kernel start index
st_acc  in  RW  initial accumulator
rd_valid / rd_ready  in/out  1/1  readback request handshake
rd_addr  in  AW  readback address
rd_dvalid  out  1  readback data valid, one cycle after accept
rd_data  out  DW  readback data
res_valid / res_ready  out/in  1/1  result handshake
res_value  out  RW  kernel result
res_cycles  out  CW  RUN cycles consumed, saturating
res_err  out  1  illegal start index or timeout
k_r_enable  out  1  to kernel `r_enable`
k_init_i / k_init_acc  out  AW/RW  to kernel `init_i` / `init_acc`
k_ctrl  out  1  to kernel `controlArr`
k_we / k_addr / k_wdata  out  1/AW/DW  to `controlArrWEnable_a` / `controlArrAddr_a` / `controlArrWData_a`
k_rdata  in  DW  from `controlArrRData_a`
k_w_enable / k_result  in  1/RW  from kernel `w_enable` / `result`

Behaviour:
- States: IDLE, LOAD, ARMED, KICK, RUN, DONE.
- Reset (async, any state) forces:
  - state IDLE, load pointer 0;
  - k_ctrl=1, k_r_enable=0, k_we=0;
  - all ready/valid outputs 0; res_value, res_cycles and res_err = 0.
- A kernel interrupted mid-run is harmless: k_ctrl=1 masks its array accesses, and the next KICK re-initialises it.
- k_ctrl=1 in every state except KICK and RUN.
- Load:
  - ld_ready=1 in IDLE, LOAD and ARMED.
  - The first accepted beat outside LOAD enters LOAD and writes address 0; every load restarts at 0.
  - Each accepted beat drives k_we=1, k_addr=pointer, k_wdata=ld_data in the same cycle, then increments the pointer.
  - Accepting ld_last, or the beat at pointer=DEPTH-1, ends the load and moves to ARMED; the pointer returns to 0. No wrap-around.
  - Entries not written keep their old contents.
- Start:
  - st_ready=1 in IDLE or ARMED, except in the cycle following a readback accept.
  - If st_i > DEPTH, the kernel is not started. The block goes to DONE with res_err=1, res_value=st_acc, res_cycles=0.
  - Otherwise KICK for exactly 1 cycle: k_r_enable=1, k_init_i=st_i, k_init_acc=st_acc (latched at accept), k_ctrl=0. Then RUN.
  - st_i=DEPTH is legal; the kernel returns st_acc.
- RUN:
  - k_ctrl=0; the cycle counter starts at 1 in the first RUN cycle.
  - k_w_enable is sampled only in RUN. Its stale high value from the previous run is cleared by the KICK edge.
  - When k_w_enable=1, latch res_value=k_result and res_cycles=counter, then go to DONE.
  - If the counter reaches TIMEOUT, go to DONE with res_err=1 and res_value=0.
- DONE:
  - res_valid=1, with outputs stable until res_ready.
  - On res_valid&&res_ready, go to IDLE. The array contents remain loaded; a re-run needs only a start command.
- Readback:
  - rd_ready=1 in IDLE, ARMED and DONE, and only when no load or start is accepted in the same cycle.
  - Accept drives k_addr=rd_addr with k_we=0.
  - Next cycle: rd_dvalid=1, rd_data=k_rdata, with k_ctrl held at 1.
- Priority when requests coincide in IDLE/ARMED: start > load > readback.

Decomposition:
- Package `norm2_ctrl_pkg`: state enum; DEPTH, AW, DW, RW defaults; a `norm2_res_t` struct {value, cycles, err}.
- No sub-module is needed.
- The kernel and its array stay outside the block; the top level wires `k_*` to `main`.

Test Plan:
- Load 1000 words a[i]=i-500, start st_i=0, st_acc=0 -> res_value=83333500, res_err=0, res_cycles=6+10*1000=10006.
- Load 3 words {3,-4,5} with ld_last on the 3rd beat, start st_i=997 on a fresh load of 1000 words whose last three are {3,-4,5}, st_acc=7 -> res_value=57, res_cycles=36.
- Start st_i=1000, st_acc=-12 -> res_value=-12, res_err=0. Start st_i=1001 -> no k_r_enable pulse, res_err=1, res_value=-12.
- Readback after load, rd_addr=999 -> rd_dvalid one cycle later with rd_data = value written at 999. Same-cycle rd_valid and st_valid -> start wins, rd_ready=0.
- Hold res_ready=0 for 5 cycles -> res_* stable. A second start without reload -> identical result.
- Assert rst_n=0 mid-RUN -> outputs at reset values immediately. After release, a new run returns the correct result.

Source files
------------

// File: rtl/norm2_ctrl_pkg.sv
// Shared types and default sizes for the norm2 kernel sequencer.
package norm2_ctrl_pkg;
  localparam int DEF_DEPTH   = 1000;
  localparam int DEF_AW      = 10;
  localparam int DEF_DW      = 27;
  localparam int DEF_RW      = 64;
  localparam int DEF_CW      = 16;
  localparam int DEF_TIMEOUT = 20000;

  typedef enum logic [2:0] {IDLE, LOAD, ARMED, KICK, RUN, DONE} state_t;

  typedef struct packed {
    logic signed [DEF_RW-1:0] value;
    logic [DEF_CW-1:0]        cycles;
    logic                     err;
  } norm2_res_t;
endpackage

// File: rtl/norm2_sequencer.sv
// Sequencer for the norm2 kernel: loads arr_a, kicks `main`, collects the
// result and time-shares the single array port with host readback.
module norm2_sequencer
  import norm2_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic signed [DW-1:0] ld_data,
  input  logic                 ld_last,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [AW-1:0]        st_i,
  input  logic signed [DEF_RW-1:0] st_acc,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_dvalid,
  output logic signed [DW-1:0] rd_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [DEF_RW-1:0] res_value,
  output logic [DEF_CW-1:0]    res_cycles,
  output logic                 res_err,
  output logic                 k_r_enable,
  output logic [AW-1:0]        k_init_i,
  output logic signed [DEF_RW-1:0] k_init_acc,
  output logic                 k_ctrl,
  output logic                 k_we,
  output logic [AW-1:0]        k_addr,
  output logic signed [DW-1:0] k_wdata,
  input  logic signed [DW-1:0] k_rdata,
  input  logic                 k_w_enable,
  input  logic signed [DEF_RW-1:0] k_result
);
  localparam int CW = DEF_CW;
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_A = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);

  state_t        state, state_nx;
  logic          live;      // low in reset so every ready is masked
  logic [AW-1:0] ptr, wr_addr;
  logic [CW-1:0] cnt;
  logic          vld_q;
  logic [1:0]    vld_pipe;  // readback: [0] accept, [1] data cycle
  logic          idle_armed, st_hs, ld_hs, rd_hs, ld_end, st_bad;
  norm2_res_t    res;

  assign vld_pipe   = {vld_q, rd_hs};
  assign rd_dvalid  = vld_pipe[1];
  assign rd_data    = vld_pipe[1] ? k_rdata : '0;
  assign res_value  = res.value;
  assign res_cycles = res.cycles;
  assign res_err    = res.err;

  // Handshake decode; start beats load, load beats readback.
  always_comb begin
    idle_armed = (state == IDLE) || (state == ARMED);
    st_ready   = live && idle_armed && !vld_pipe[1];
    st_hs      = st_valid && st_ready;
    ld_ready   = live && (idle_armed || state == LOAD) && !st_hs;
    ld_hs      = ld_valid && ld_ready;
    rd_ready   = live && (idle_armed || state == DONE) && !st_hs && !ld_hs;
    rd_hs      = rd_valid && rd_ready;
    wr_addr    = (state == LOAD) ? ptr : '0;
    ld_end     = ld_last || (wr_addr == LAST_A);
    st_bad     = {1'b0, st_i} > DEPTH_A;
  end

  // Next state plus kernel/array port drive.
  always_comb begin
    state_nx   = state;
    k_ctrl     = 1'b1;
    k_r_enable = 1'b0;
    k_we       = ld_hs;
    k_addr     = ld_hs ? wr_addr : (rd_hs ? rd_addr : '0);
    k_wdata    = ld_hs ? ld_data : '0;
    res_valid  = 1'b0;
    unique case (state)
      IDLE, ARMED: begin
        if (st_hs)      state_nx = st_bad ? DONE : KICK;
        else if (ld_hs) state_nx = ld_end ? ARMED : LOAD;
      end
      LOAD: if (ld_hs && ld_end) state_nx = ARMED;
      KICK: begin
        k_ctrl     = 1'b0;
        k_r_enable = 1'b1;
        state_nx   = RUN;
      end
      RUN: begin
        k_ctrl = 1'b0;
        if (k_w_enable || cnt == TMO) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  // Datapath: load pointer, run counter, latched start args and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      vld_q      <= 1'b0;
      k_init_i   <= '0;
      k_init_acc <= '0;
      res        <= '0;
    end else begin
      live  <= 1'b1;
      vld_q <= vld_pipe[0];
      if (ld_hs) ptr <= ld_end ? '0 : wr_addr + AW'(1);
      if (state == KICK) cnt <= CW'(1);
      else if (state == RUN && cnt != '1) cnt <= cnt + CW'(1);
      if (st_hs) begin
        k_init_i   <= st_i;
        k_init_acc <= st_acc;
        // An out-of-range index never reaches the kernel; echo the acc.
        if (st_bad) res <= '{value: st_acc, cycles: '0, err: 1'b1};
        else        res <= '0;
      end
      if (state == RUN) begin
        if (k_w_enable)      res <= '{value: k_result, cycles: cnt, err: 1'b0};
        else if (cnt == TMO) res <= '{value: '0, cycles: cnt, err: 1'b1};
      end
    end
  end
endmodule

// File: tb/tb_norm2_sequencer.sv
// Bench for norm2_sequencer with behavioural arr_a and `main` kernel models.
module tb_norm2_sequencer;
  localparam int N = 1000;

  logic clk = 0, rst_n = 0;
  logic ld_valid = 0, ld_ready, ld_last = 0;
  logic signed [26:0] ld_data = 0;
  logic st_valid = 0, st_ready;
  logic [9:0] st_i = 0;
  logic signed [63:0] st_acc = 0;
  logic rd_valid = 0, rd_ready, rd_dvalid;
  logic [9:0] rd_addr = 0;
  logic signed [26:0] rd_data;
  logic res_valid, res_ready = 0, res_err;
  logic signed [63:0] res_value;
  logic [15:0] res_cycles;
  logic k_r_enable, k_ctrl, k_we;
  logic [9:0] k_init_i, k_addr;
  logic signed [63:0] k_init_acc;
  logic signed [26:0] k_wdata, k_rdata = 0;
  logic k_w_enable = 0;
  logic signed [63:0] k_result = 0;

  int checks = 0, failures = 0, kick_cnt = 0;
  logic signed [26:0] mem [N];      // physical array contents
  logic signed [26:0] ref_mem [N];  // contents the host intended to load
  logic signed [26:0] ldv [N];
  bit kbusy = 0, khang = 0;
  int kcnt = 0, klen = 0;

  norm2_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .st_valid(st_valid), .st_ready(st_ready), .st_i(st_i), .st_acc(st_acc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_dvalid(rd_dvalid), .rd_data(rd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_cycles(res_cycles), .res_err(res_err),
    .k_r_enable(k_r_enable), .k_init_i(k_init_i), .k_init_acc(k_init_acc),
    .k_ctrl(k_ctrl), .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata),
    .k_rdata(k_rdata), .k_w_enable(k_w_enable), .k_result(k_result)
  );

  always #5 clk = ~clk;

  // arr_a: 1-cycle read, host side of the port only while k_ctrl=1
  always @(posedge clk)
    if (k_ctrl && k_addr < 10'(N)) begin
      if (k_we) mem[k_addr] <= k_wdata;
      k_rdata <= mem[k_addr];
    end

  function automatic longint kern_sum(input int i0, input longint acc);
    longint s = acc;
    for (int k = i0; k < N; k++) s += longint'(mem[k]) * longint'(mem[k]);
    return s;
  endfunction

  // kernel: w_enable rises 6+10*(N-i) cycles after r_enable and stays high
  always @(posedge clk) begin
    if (k_r_enable) begin
      kick_cnt   <= kick_cnt + 1;
      kbusy      <= 1;
      kcnt       <= 1;
      k_w_enable <= 0;
      klen       <= 6 + 10 * (N - int'(k_init_i));
      k_result   <= kern_sum(int'(k_init_i), k_init_acc);
    end else if (kbusy && !khang) begin
      kcnt <= kcnt + 1;
      if (kcnt + 1 == klen) begin k_w_enable <= 1; kbusy <= 0; end
    end
  end

  function automatic longint ref_sum(input int i0, input longint acc);
    longint s = acc;
    for (int k = i0; k < N; k++) s += longint'(ref_mem[k]) * longint'(ref_mem[k]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ld_ready"}, 64'(ld_ready), 64'(0));
    chk({tag, "_st_ready"}, 64'(st_ready), 64'(0));
    chk({tag, "_rd_ready"}, 64'(rd_ready), 64'(0));
    chk({tag, "_rd_dvalid"}, 64'(rd_dvalid), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_k_ctrl"}, 64'(k_ctrl), 64'(1));
    chk({tag, "_k_r_enable"}, 64'(k_r_enable), 64'(0));
    chk({tag, "_k_we"}, 64'(k_we), 64'(0));
    chk({tag, "_res_value"}, res_value, 64'(0));
    chk({tag, "_res_cycles"}, 64'(res_cycles), 64'(0));
    chk({tag, "_res_err"}, 64'(res_err), 64'(0));
  endtask

  task automatic do_load(input string tag, input int n, input bit use_last);
    int stalls = 0;
    for (int k = 0; k < n; k++) begin
      ld_valid = 1; ld_data = ldv[k]; ld_last = use_last && (k == n - 1);
      #1 if (ld_ready !== 1'b1) stalls++;
      @(negedge clk);
      ref_mem[k] = ldv[k];
    end
    ld_valid = 0; ld_last = 0;
    chk({tag, "_ld_stalls"}, 64'(stalls), 64'(0));
    #1 chk({tag, "_armed_st_ready"}, 64'(st_ready), 64'(1));
  endtask

  task automatic readback(input string tag, input int a);
    rd_valid = 1; rd_addr = 10'(a);
    #1 chk({tag, "_rd_ready"}, 64'(rd_ready), 64'(1));
    @(negedge clk); rd_valid = 0;
    chk({tag, "_rd_dvalid"}, 64'(rd_dvalid), 64'(1));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(ref_mem[a]));
    chk({tag, "_st_blocked"}, 64'(st_ready), 64'(0));
    chk({tag, "_k_ctrl"}, 64'(k_ctrl), 64'(1));
    @(negedge clk);
    chk({tag, "_rd_dvalid_drop"}, 64'(rd_dvalid), 64'(0));
  endtask

  task automatic start_cmd(input string tag, input int i0, input longint acc);
    st_valid = 1; st_i = 10'(i0); st_acc = acc;
    #1 chk({tag, "_st_ready"}, 64'(st_ready), 64'(1));
    @(negedge clk); st_valid = 0;
  endtask

  task automatic wait_res(input string tag, input int k0, input bit e_err, input longint e_val,
                          input int e_cyc, input int e_kicks, input int hold);
    int t = 0;
    while (!res_valid && t < 25000) begin @(negedge clk); t++; end
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(1));
    chk({tag, "_value"}, res_value, e_val);
    chk({tag, "_cycles"}, 64'(res_cycles), 64'(e_cyc));
    chk({tag, "_err"}, 64'(res_err), 64'(e_err));
    chk({tag, "_kicks"}, 64'(kick_cnt - k0), 64'(e_kicks));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(res_valid), 64'(1));
      chk({tag, "_hold_value"}, res_value, e_val);
      chk({tag, "_hold_cycles"}, 64'(res_cycles), 64'(e_cyc));
    end
    res_ready = 1;
    @(negedge clk); res_ready = 0;
    chk({tag, "_released"}, 64'(res_valid), 64'(0));
  endtask

  task automatic run(input string tag, input int i0, input longint acc, input int hold);
    int k0 = kick_cnt;
    start_cmd(tag, i0, acc);
    wait_res(tag, k0, 0, ref_sum(i0, acc), 6 + 10 * (N - i0), 1, hold);
  endtask

  initial begin
    int k0;
    longint a;
    for (int k = 0; k < N; k++) begin mem[k] = 0; ref_mem[k] = 0; end
    // reset with all requests pending: nothing may be granted
    ld_valid = 1; st_valid = 1; rd_valid = 1;
    #12 chk_reset("rst");
    ld_valid = 0; st_valid = 0; rd_valid = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // full load a[i]=i-500, ends at DEPTH-1 without ld_last
    for (int k = 0; k < N; k++) ldv[k] = 27'(k - 500);
    do_load("load_full", N, 0);
    readback("rb999", 999);
    readback("rb_rand", int'($urandom_range(0, N - 1)));
    run("run0", 0, 0, 5);
    chk("run0_known", 64'(ref_sum(0, 0)), 64'(83333500));
    // re-run without reload, read back while the result is parked
    k0 = kick_cnt;
    start_cmd("rerun", 0, 0);
    while (!res_valid && (kick_cnt - k0) < 2 && k0 + 20000 > 0) begin
      @(negedge clk);
      if (res_valid) break;
      if (k_ctrl === 1'b1 && !res_valid && kick_cnt != k0) break;
    end
    wait_res("rerun", k0, 0, 64'(83333500), 10006, 1, 0);

    // short load with ld_last, tail of array untouched
    ldv[0] = 3; ldv[1] = -4; ldv[2] = 5;
    do_load("load3", 3, 1);
    readback("rb0", 0);
    readback("rb2", 2);
    readback("rb3_old", 3);
    // fresh random load ending in {3,-4,5}
    for (int k = 0; k < N; k++) ldv[k] = 27'($urandom);
    ldv[997] = 3; ldv[998] = -4; ldv[999] = 5;
    do_load("load_rand", N, 0);
    run("run997", 997, 7, 0);
    chk("run997_known", 64'(ref_sum(997, 7)), 64'(57));
    run("run1000", 1000, -12, 0);
    k0 = kick_cnt;
    start_cmd("run1001", 1001, -12);
    wait_res("run1001", k0, 1, -12, 0, 0, 0);

    // start and readback together: start wins
    a = longint'($urandom_range(0, 100000));
    k0 = kick_cnt;
    rd_valid = 1; rd_addr = 10'd5; st_valid = 1; st_i = 10'd995; st_acc = a;
    #1 chk("coinc_rd_ready", 64'(rd_ready), 64'(0));
    chk("coinc_st_ready", 64'(st_ready), 64'(1));
    @(negedge clk); rd_valid = 0; st_valid = 0;
    chk("coinc_no_rd", 64'(rd_dvalid), 64'(0));
    wait_res("coinc", k0, 0, ref_sum(995, a), 56, 1, 0);

    // reset in the middle of a run
    start_cmd("midrst", 0, 0);
    repeat (50) @(negedge clk);
    chk("midrst_running", 64'(k_ctrl), 64'(0));
    #2 rst_n = 0;
    #1 chk_reset("midrst");
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    run("post_rst", int'($urandom_range(980, 999)), longint'($urandom_range(0, 999)), 0);

    // kernel never answers: timeout
    khang = 1;
    k0 = kick_cnt;
    start_cmd("tmo", 0, 5);
    wait_res("tmo", k0, 1, 0, 20000, 1, 0);
    khang = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
